// File: rtl/stream_fifo_ctrl_if.sv
// Register bus, upstream FWFT FIFO and ready/valid sink signals of stream_fifo_ctrl.
// The slave modport is the controller side; master is the host/environment side.
interface stream_fifo_ctrl_if #(
    parameter int unsigned ABUSWIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ABUSWIDTH-1:0]  bus_add;
    logic [7:0]            bus_data_in;
    logic [7:0]            bus_data_out;
    logic                  bus_wr;
    logic                  bus_rd;
    logic                  fifo_read_next_out;
    logic                  fifo_empty_in;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  stream_ready;
    logic                  stream_valid;
    logic [DATA_WIDTH-1:0] stream_data;
    logic                  stream_last;

    modport slave (
        input  bus_add, bus_data_in, bus_wr, bus_rd, fifo_empty_in, fifo_data, stream_ready,
        output bus_data_out, fifo_read_next_out, stream_valid, stream_data, stream_last
    );

    modport master (
        output bus_add, bus_data_in, bus_wr, bus_rd, fifo_empty_in, fifo_data, stream_ready,
        input  bus_data_out, fifo_read_next_out, stream_valid, stream_data, stream_last
    );
endinterface

// File: rtl/stream_fifo_ctrl.sv
// Stream FIFO controller: buffers upstream FWFT words in an internal FIFO and streams
// an exact host-requested word count to a ready/valid sink, with pad/stall, abort and snapshots.
module stream_fifo_ctrl #(
    parameter int unsigned ABUSWIDTH   = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH_BITS  = 10,
    parameter int unsigned COUNT_WIDTH = 24
) (
    input logic               BUS_CLK,
    input logic               BUS_RST_N,
    stream_fifo_ctrl_if.slave sif
);
    localparam int unsigned         PTR_WIDTH = DEPTH_BITS + 1;
    localparam int unsigned         DEPTH     = 1 << DEPTH_BITS;
    localparam logic [PTR_WIDTH-1:0] PTR_MSB  = PTR_WIDTH'(DEPTH);
    localparam logic [7:0]          VERSION   = 8'd2;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  head;
    logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr, fill;
    logic                   full, empty, push;

    logic [ABUSWIDTH-1:0]   addr;
    logic                   soft_rst, start_wr, abort_wr, start_ok;
    logic [23:0]            req_count, req_next;
    logic [COUNT_WIDTH-1:0] start_cnt, remaining, rem_after;
    logic                   pad_mode;
    logic [15:0]            pad_count;

    logic                   out_valid, out_last, accept;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   load_fifo, load_pad;

    logic [23:0]            rem24;
    logic [15:0]            fill16;
    logic [7:0]             snap_fill_hi, snap_pad_hi;
    logic [15:0]            snap_rem_hi;
    logic [7:0]             rdata, rdata_next;

    // Internal FIFO status; pointers carry one extra wrap bit
    assign fill   = wr_ptr - rd_ptr;
    assign full   = (wr_ptr ^ rd_ptr) == PTR_MSB;
    assign empty  = wr_ptr == rd_ptr;
    assign push   = !sif.fifo_empty_in && !full;
    assign head   = mem[rd_ptr[DEPTH_BITS-1:0]];
    assign fill16 = 16'(fill);
    assign rem24  = 24'(remaining);

    assign addr      = sif.bus_add;
    assign soft_rst  = sif.bus_wr && (addr == ABUSWIDTH'(0));
    assign start_wr  = sif.bus_wr && (addr == ABUSWIDTH'(3));
    assign abort_wr  = sif.bus_wr && (addr == ABUSWIDTH'(4)) && sif.bus_data_in[1];
    assign req_next  = {sif.bus_data_in, req_count[15:0]};
    assign start_cnt = req_next[COUNT_WIDTH-1:0];
    assign start_ok  = start_wr && (state == IDLE) && (start_cnt != '0);

    assign accept    = out_valid && sif.stream_ready;
    assign rem_after = (accept && remaining != '0) ? remaining - COUNT_WIDTH'(1) : remaining;

    assign sif.fifo_read_next_out = push;
    assign sif.stream_valid       = out_valid;
    assign sif.stream_data        = out_data;
    assign sif.stream_last        = out_last;
    assign sif.bus_data_out       = rdata;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) state <= IDLE;
        else            state <= state_next;
    end

    // Next state and word-load decision; a load needs a free output slot and words still owed
    always_comb begin
        state_next = state;
        load_fifo  = 1'b0;
        load_pad   = 1'b0;
        case (state)
            IDLE: if (start_ok) state_next = RUN;
            RUN: begin
                if (abort_wr) begin
                    if (!out_valid || accept) state_next = IDLE;
                end else if (accept && out_last) begin
                    state_next = IDLE;
                end else if ((!out_valid || accept) && rem_after != '0) begin
                    if (!empty)        load_fifo = 1'b1;
                    else if (pad_mode) load_pad  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (soft_rst) begin
            state_next = IDLE;
            load_fifo  = 1'b0;
            load_pad   = 1'b0;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge BUS_CLK) begin
        if (push) mem[wr_ptr[DEPTH_BITS-1:0]] <= sif.fifo_data;
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)      wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (load_fifo) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        end
    end

    // Output word register, remaining count and pad counter
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            remaining <= '0;
            pad_count <= '0;
        end else if (soft_rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            remaining <= '0;
            pad_count <= '0;
        end else begin
            if (start_ok)           remaining <= start_cnt;
            else if (state == RUN)  remaining <= abort_wr ? '0 : rem_after;

            if (start_ok)                                pad_count <= '0;
            else if (load_pad && pad_count != 16'hFFFF) pad_count <= pad_count + 16'd1;

            if (state == RUN) begin
                if (abort_wr) begin
                    if (out_valid && !accept) begin
                        out_last <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end else if (load_fifo || load_pad) begin
                    out_valid <= 1'b1;
                    out_data  <= load_fifo ? head : '0;
                    out_last  <= rem_after == COUNT_WIDTH'(1);
                end else if (accept) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

    // Register writes, read snapshots and registered read data
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            req_count    <= '0;
            pad_mode     <= 1'b0;
            snap_fill_hi <= '0;
            snap_rem_hi  <= '0;
            snap_pad_hi  <= '0;
            rdata        <= '0;
        end else if (soft_rst) begin
            req_count    <= '0;
            pad_mode     <= 1'b0;
            snap_fill_hi <= '0;
            snap_rem_hi  <= '0;
            snap_pad_hi  <= '0;
            rdata        <= '0;
        end else begin
            if (sif.bus_wr) begin
                case (addr)
                    ABUSWIDTH'(1): req_count[7:0]   <= sif.bus_data_in;
                    ABUSWIDTH'(2): req_count[15:8]  <= sif.bus_data_in;
                    ABUSWIDTH'(3): req_count[23:16] <= sif.bus_data_in;
                    ABUSWIDTH'(4): pad_mode         <= sif.bus_data_in[0];
                    default: ;
                endcase
            end
            if (sif.bus_rd) begin
                rdata <= rdata_next;
                case (addr)
                    ABUSWIDTH'(5):  snap_fill_hi <= fill16[15:8];
                    ABUSWIDTH'(7):  snap_rem_hi  <= rem24[23:8];
                    ABUSWIDTH'(11): snap_pad_hi  <= pad_count[15:8];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata_next = '0;
        case (addr)
            ABUSWIDTH'(0):  rdata_next = VERSION;
            ABUSWIDTH'(1):  rdata_next = req_count[7:0];
            ABUSWIDTH'(2):  rdata_next = req_count[15:8];
            ABUSWIDTH'(3):  rdata_next = req_count[23:16];
            ABUSWIDTH'(4):  rdata_next = {7'd0, pad_mode};
            ABUSWIDTH'(5):  rdata_next = fill16[7:0];
            ABUSWIDTH'(6):  rdata_next = snap_fill_hi;
            ABUSWIDTH'(7):  rdata_next = rem24[7:0];
            ABUSWIDTH'(8):  rdata_next = snap_rem_hi[7:0];
            ABUSWIDTH'(9):  rdata_next = snap_rem_hi[15:8];
            ABUSWIDTH'(10): rdata_next = {5'd0, full, empty, state == RUN};
            ABUSWIDTH'(11): rdata_next = pad_count[7:0];
            ABUSWIDTH'(12): rdata_next = snap_pad_hi;
            default:        rdata_next = '0;
        endcase
    end
endmodule

// File: doc/stream_fifo_ctrl.md
Name: stream_fifo_ctrl

Overview:
Single-clock, parametrised successor to the SRAM-backed stream FIFO core.
- Buffers words pulled from an upstream first-word-fall-through FIFO into an internal block-RAM FIFO of configurable width and depth.
- Streams an exact, host-requested word count to a ready/valid sink, with a LAST marker on the final word.
- Adds a selectable pad-or-stall mode, abort, a pad counter and coherent fill/remaining snapshots, all on the 8-bit register bus.

Parameters:
ABUSWIDTH, 16, bus address width.
DATA_WIDTH, 16, word width; must be a multiple of 8 in the range 8..32.
DEPTH_BITS, 10, internal FIFO depth is 2^DEPTH_BITS words; range 4..15.
COUNT_WIDTH, 24, width of the request and remaining counters; range up to 24.

Ports:
BUS_CLK  in  1  single clock for the whole block.
BUS_RST_N  in  1  reset, asynchronous assert, active-low.
BUS_ADD  in  ABUSWIDTH  register address.
BUS_DATA_IN  in  8  write data.
BUS_DATA_OUT  out  8  read data; registered, valid the cycle after BUS_RD.
BUS_WR  in  1  write strobe.
BUS_RD  in  1  read strobe.
FIFO_READ_NEXT_OUT  out  1  pop strobe to the upstream FIFO.
FIFO_EMPTY_IN  in  1  upstream FIFO empty flag.
FIFO_DATA  in  DATA_WIDTH  upstream head word (first-word fall-through).
STREAM_READY  in  1  sink accepts a word.
STREAM_VALID  out  1  word present on STREAM_DATA.
STREAM_DATA  out  DATA_WIDTH  output word.
STREAM_LAST  out  1  high together with the final word of a transfer.

Behaviour:
Reset and soft reset
- BUS_RST_N low, or a soft reset (write to address 0), clears the following:
  - the FIFO, and the FSM to IDLE;
  - all counters, CONF and snapshots;
  - STREAM_VALID, STREAM_LAST, STREAM_DATA, BUS_DATA_OUT to 0.
- Soft reset is synchronous and takes effect at the write edge.
- Reset mid-transfer drops the pending word; no LAST is issued.

Register map
- 0: read VERSION=2.
- 1-3: REQ_COUNT bytes [7:0], [15:8], [23:16]; read-back supported. A write to address 3 is START.
- 4: CONF.
  - bit0 PAD_MODE: 1 = emit zero words when the FIFO is empty; 0 = stall.
  - bit1 ABORT: write-1, self-clearing, reads 0.
- 5-6: FILL snapshot, 16 bits. A read of address 5 latches the FILL value; address 6 returns the latched high byte.
- 7-9: REMAINING snapshot. A read of address 7 latches the value; addresses 8-9 return the latched bytes.
- 10: STATUS, bit0 BUSY, bit1 EMPTY, bit2 FULL.
- 11-12: PAD_COUNT snapshot, latched on read of address 11. The counter saturates at 0xFFFF and is cleared by START.
- Unmapped addresses read 0.

Input side
- FIFO_READ_NEXT_OUT = !FIFO_EMPTY_IN & !full, evaluated combinationally.
- FIFO_DATA is written into the internal FIFO on the same edge.
- Pointers are DEPTH_BITS+1 wide, so the FIFO holds exactly 2^DEPTH_BITS words.
  - full = pointers differ only in the MSB; empty = pointers equal.
- A write is blocked when full.
- A simultaneous read and write at full does not admit the new word that cycle.

FSM (IDLE, RUN)
- IDLE to RUN: on START with REQ_COUNT != 0; remaining is loaded with REQ_COUNT.
- START with REQ_COUNT = 0: ignored.
- START while in RUN: ignored.
- RUN: the output register loads a word whenever it is empty, or is being accepted this cycle, and remaining-in-flight > 0.
  - Word source is the FIFO head if the FIFO is non-empty.
  - Otherwise, if PAD_MODE=1, the word is 0 and PAD_COUNT increments.
  - Otherwise no load.
- A handshake (STREAM_VALID & STREAM_READY) decrements remaining.
- STREAM_LAST is high with the word whose acceptance makes remaining 0; the FSM returns to IDLE at that edge.
- While STREAM_VALID=1 and STREAM_READY=0: STREAM_DATA and STREAM_LAST are held stable.
- Throughput: 1 word per cycle with STREAM_READY held high and data available.
- Latency: first STREAM_VALID within 3 cycles of the START edge when the FIFO is non-empty.
- ABORT in RUN:
  - if no word is pending, go to IDLE and clear remaining;
  - if a word is pending, it becomes the last word (STREAM_LAST=1) and the FSM returns to IDLE on its acceptance. Remaining is cleared.
- ABORT in IDLE: no effect.
- FIFO words not streamed remain buffered.

Arithmetic
- All counters wrap-free; remaining never underflows.
- FILL = wr_ptr - rd_ptr, modulo 2^(DEPTH_BITS+1), zero-extended to 16 bits.

Test Plan:
- Basic stream: preload 8 words 0x0001..0x0008; REQ_COUNT=8, START, READY=1 -> 8 consecutive valid words 0x0001..0x0008, LAST on 0x0008, BUSY=0 afterwards, FILL=0.
- Backpressure: REQ_COUNT=4, READY toggles 1,0,0,1,... -> data held stable during READY=0, exactly 4 handshakes, no duplicate or lost words.
- Pad mode: PAD_MODE=1, 2 words buffered, REQ_COUNT=5 -> 2 data words then 3 zero words, LAST on the 5th, PAD_COUNT=3. With PAD_MODE=0 -> stalls after 2 until 3 more words arrive.
- Full boundary: DEPTH_BITS=4, upstream never empty, READY=0 -> exactly 16 pops, FULL=1, FIFO_READ_NEXT_OUT=0, FILL=16. One handshake then restores FIFO_READ_NEXT_OUT for a single pop.
- Abort: REQ_COUNT=100, accept 10 words, hold READY=0 with a word pending, write ABORT -> pending word gets LAST=1, IDLE after acceptance, REMAINING snapshot=0, remaining FIFO words intact.
- Reset mid-transfer: assert BUS_RST_N low during RUN -> STREAM_VALID=0 immediately (async), FIFO empty, registers at defaults. Also: START with REQ_COUNT=0 -> no activity.
